div_check_arbiter: RTL and testbench

//  Shares one divisibility-check datapath (divide-by-2 / divide-by-3 / divide-by-6 on a

---
 rtl/div_pkg.sv | 9 +
 rtl/div_check_unit.sv | 32 +++
 rtl/div_check_arbiter.sv | 106 ++++++++++
 tb/tb_div_check_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Check-mode encodings shared by the divisibility arbiter and its check unit.
package div_pkg;

  localparam logic [1:0] MODE_DIV2 = 2'b00;
  localparam logic [1:0] MODE_DIV3 = 2'b01;
  localparam logic [1:0] MODE_DIV6 = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/div_check_unit.sv
// Combinational divisibility check (by 2, 3 or 6) of one unsigned operand.
// Zero latency; no flow control.
module div_check_unit
  import div_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] operand,
  input  logic [1:0]        mode,
  output logic              div,
  output logic              err
);

  logic div2;
  logic div3;

  assign div2 = ~operand[0];
  // Modulo by a constant; DATA_W must be at least 2 so the divisor fits.
  assign div3 = ((operand % DATA_W'(3)) == '0);

  always_comb begin
    div = 1'b0;
    err = 1'b0;
    case (mode)
      MODE_DIV2: div = div2;
      MODE_DIV3: div = div3;
      MODE_DIV6: div = div2 & div3;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/div_check_arbiter.sv
// Round-robin share of one divisibility checker among NUM_REQ requesters; req in cycle n
// gives gnt + registered response in n+1. A held response (valid & ~ready) stalls grants.
module div_check_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_mode,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_div,
  output logic                      rsp_err,
  output logic [CNT_W-1:0]          hit_count,
  input  logic                      cnt_clr
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    ptr_nxt;
  logic [DATA_W-1:0]  win_data;
  logic [1:0]         win_mode;
  logic               chk_div;
  logic               chk_err;
  logic               can_issue;
  logic               issue;
  logic               accept;

  // gnt doubles as last_gnt: the previous winner sits out one cycle.
  assign elig      = req & ~gnt;
  assign can_issue = ~rsp_valid | rsp_ready;
  assign issue     = can_issue & win_found;
  assign accept    = rsp_valid & rsp_ready;

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign ptr_nxt  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign win_data = req_data[int'(win_id)*DATA_W +: DATA_W];
  assign win_mode = req_mode[int'(win_id)*2 +: 2];

  div_check_unit #(
    .DATA_W(DATA_W)
  ) u_check (
    .operand(win_data),
    .mode   (win_mode),
    .div    (chk_div),
    .err    (chk_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_div   <= 1'b0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else if (issue) begin
      gnt       <= NUM_REQ'(1) << win_id;
      rsp_valid <= 1'b1;
      rsp_id    <= win_id;
      rsp_div   <= chk_div;
      rsp_err   <= chk_err;
      rr_ptr    <= ptr_nxt;
    end else begin
      gnt <= '0;
      if (accept) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Clear beats increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
    end else if (cnt_clr) begin
      hit_count <= '0;
    end else if (accept && rsp_div && (hit_count != '1)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_check_arbiter.sv
// Directed, table-driven bench for div_check_arbiter (4 requesters, 4-bit operands).
module tb_div_check_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [7:0]  req_mode;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_div;
  logic        rsp_err;
  logic [7:0]  hit_count;
  logic        cnt_clr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [15:0] data;
    logic [7:0]  mode;
    logic        rdy;
    logic        clr;
    logic [3:0]  gnt;
    logic        vld;
    logic [1:0]  id;
    logic        div;
    logic        err;
    logic [7:0]  hit;
  } vec_t;

  localparam int NROWS = 18;
  vec_t tbl [NROWS];

  div_check_arbiter #(
    .NUM_REQ(4),
    .DATA_W (4),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .req_mode (req_mode),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_div  (rsp_div),
    .rsp_err  (rsp_err),
    .hit_count(hit_count),
    .cnt_clr  (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] rq, input logic [15:0] d, input logic [7:0] m,
                              input logic rd, input logic cl, input logic [3:0] g,
                              input logic v, input logic [1:0] id, input logic dv,
                              input logic er, input logic [7:0] h);
    vec_t r;
    r.req = rq; r.data = d; r.mode = m; r.rdy = rd; r.clr = cl;
    r.gnt = g; r.vld = v; r.id = id; r.div = dv; r.err = er; r.hit = h;
    return r;
  endfunction

  // Packed order: gnt, valid, id, div, err, hit_count
  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b vld=%b id=%0d div=%b err=%b hit=%0d, want gnt=%b vld=%b id=%0d div=%b err=%b hit=%0d",
               nm, act[16:13], act[12], act[11:10], act[9], act[8], act[7:0],
               exp[16:13], exp[12], exp[11:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic run_row(input vec_t v, input string nm);
    req = v.req; req_data = v.data; req_mode = v.mode; rsp_ready = v.rdy; cnt_clr = v.clr;
    @(posedge clk); #1;
    check(nm, {gnt, rsp_valid, rsp_id, rsp_div, rsp_err, hit_count},
              {v.gnt, v.vld, v.id, v.div, v.err, v.hit});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; req_data = '0; req_mode = '0; rsp_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // data {r3..r0} = {8,7,9,6}; modes {00,10,01,10}
    tbl[0]  = mk(4'b1111, 16'h8796, 8'h26, 1, 0, 4'b0001, 1, 0, 1, 0, 0);
    tbl[1]  = mk(4'b1111, 16'h8796, 8'h26, 1, 0, 4'b0010, 1, 1, 1, 0, 1);
    tbl[2]  = mk(4'b1111, 16'h8796, 8'h26, 1, 0, 4'b0100, 1, 2, 0, 0, 2);
    tbl[3]  = mk(4'b1111, 16'h8796, 8'h26, 1, 0, 4'b1000, 1, 3, 1, 0, 2);
    tbl[4]  = mk(4'b0000, 16'h8796, 8'h26, 1, 0, 4'b0000, 0, 3, 1, 0, 3);
    // backpressure: req0 response held while req1 waits
    tbl[5]  = mk(4'b0001, 16'h8796, 8'h26, 0, 0, 4'b0001, 1, 0, 1, 0, 3);
    tbl[6]  = mk(4'b0010, 16'h8796, 8'h26, 0, 0, 4'b0000, 1, 0, 1, 0, 3);
    tbl[7]  = mk(4'b0010, 16'h8796, 8'h26, 0, 0, 4'b0000, 1, 0, 1, 0, 3);
    tbl[8]  = mk(4'b0010, 16'h8796, 8'h26, 0, 0, 4'b0000, 1, 0, 1, 0, 3);
    tbl[9]  = mk(4'b0010, 16'h8796, 8'h26, 1, 0, 4'b0010, 1, 1, 1, 0, 4);
    tbl[10] = mk(4'b0000, 16'h8796, 8'h26, 1, 0, 4'b0000, 0, 1, 1, 0, 5);
    // reserved mode on req2 with data 6
    tbl[11] = mk(4'b0100, 16'h8696, 8'h36, 1, 0, 4'b0100, 1, 2, 0, 1, 5);
    tbl[12] = mk(4'b0000, 16'h8696, 8'h36, 1, 0, 4'b0000, 0, 2, 0, 1, 5);
    // single persistent requester: every other cycle
    tbl[13] = mk(4'b1000, 16'h8696, 8'h36, 1, 0, 4'b1000, 1, 3, 1, 0, 5);
    tbl[14] = mk(4'b1000, 16'h8696, 8'h36, 1, 0, 4'b0000, 0, 3, 1, 0, 6);
    tbl[15] = mk(4'b1000, 16'h8696, 8'h36, 1, 0, 4'b1000, 1, 3, 1, 0, 6);
    tbl[16] = mk(4'b0000, 16'h8696, 8'h36, 1, 0, 4'b0000, 0, 3, 1, 0, 7);
    tbl[17] = mk(4'b0000, 16'h8696, 8'h36, 1, 1, 4'b0000, 0, 3, 1, 0, 0);

    do_reset();
    check("reset_state", {gnt, rsp_valid, rsp_id, rsp_div, rsp_err, hit_count}, 17'd0);

    // single req0, 12 under div6
    run_row(mk(4'b0001, 16'h000C, 8'h02, 1, 0, 4'b0001, 1, 0, 1, 0, 0), "single_req0");
    run_row(mk(4'b0000, 16'h000C, 8'h02, 1, 0, 4'b0000, 0, 0, 1, 0, 1), "single_accept");
    run_row(mk(4'b0001, 16'h000C, 8'h02, 0, 0, 4'b0001, 1, 0, 1, 0, 1), "hold_resp");

    // async reset while a response is pending
    #2 reset_n = 1'b0;
    #1 check("reset_mid_rsp", {gnt, rsp_valid, rsp_id, rsp_div, rsp_err, hit_count}, 17'd0);
    req = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("reset_held", {gnt, rsp_valid, rsp_id, rsp_div, rsp_err, hit_count}, 17'd0);

    for (int i = 0; i < NROWS; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
    end

    // saturation: req0 (6, div6) granted on odd edges, accepted on even edges
    do_reset();
    req = 4'b0001; req_data = 16'h0006; req_mode = 8'h02; rsp_ready = 1'b1;
    for (int k = 1; k <= 514; k++) begin
      cnt_clr = (k == 514);
      @(posedge clk); #1;
      if (k == 508 || k == 510 || k == 512) begin
        checks++;
        if (hit_count !== 8'(((k / 2) > 255) ? 255 : (k / 2))) begin
          errors++;
          $display("FAIL sat_k%0d: hit_count=%0d want %0d", k, hit_count,
                   ((k / 2) > 255) ? 255 : (k / 2));
        end
      end
    end
    cnt_clr = 1'b0;
    check("clr_wins", {4'b0000, rsp_valid, 2'd0, 1'b0, 1'b0, hit_count}, {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
